// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined RV immediate generator.
// Contents:
//   - base-opcode localparams (instr[6:0])
//   - imm_fmt_t : 3-bit format code reported on out_fmt
//   - imm_res_t : decoded result {imm, fmt, illegal}; imm is held at the
//                 widest supported XLEN and trimmed by the consumer
//   - sext32    : sign-extend a 32-bit value to the widest XLEN
package imm_pkg;

    localparam int IMM_MAX_W = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_t;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
    } imm_res_t;

    // Every base immediate fits in 32 bits once assembled, so one
    // extension helper covers all formats for both XLEN values.
    function automatic logic [IMM_MAX_W-1:0] sext32(input logic [31:0] v);
        return {{(IMM_MAX_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: raw instruction word -> imm_res_t.
// Ports:
//   i_instr [31:0]  raw instruction word
//   o_res           decoded {imm (sign/zero-extended to 64), fmt, illegal}
// Parameter XLEN only affects the shift-amount width (5 bits for 32, 6 for 64);
// all other immediates are sign-extended to 64 and trimmed downstream.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] i_instr,
    output imm_res_t    o_res
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [IMM_MAX_W-1:0] w_shamt;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];

    // Raw 32-bit immediates per format, before extension to 64 bits.
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'h000};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};

    // RV64 shifts take a 6-bit shamt; instr[25] belongs to funct7 on RV32.
    assign w_shamt = (XLEN == 64) ? {58'd0, i_instr[25:20]}
                                  : {59'd0, i_instr[24:20]};

    // Format selection by opcode; a non-11 low pair overrides everything.
    always_comb begin
        o_res.imm     = 64'd0;
        o_res.fmt     = FMT_NONE;
        o_res.illegal = 1'b0;
        if (i_instr[1:0] != 2'b11) begin
            o_res.illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_LOAD, OPC_JALR: begin
                    o_res.imm = sext32(w_imm_i);
                    o_res.fmt = FMT_I;
                end
                OPC_OPIMM: begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        o_res.imm = w_shamt;
                        o_res.fmt = FMT_SHAMT;
                    end else begin
                        o_res.imm = sext32(w_imm_i);
                        o_res.fmt = FMT_I;
                    end
                end
                OPC_STORE: begin
                    o_res.imm = sext32(w_imm_s);
                    o_res.fmt = FMT_S;
                end
                OPC_BRANCH: begin
                    o_res.imm = sext32(w_imm_b);
                    o_res.fmt = FMT_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    o_res.imm = sext32(w_imm_u);
                    o_res.fmt = FMT_U;
                end
                OPC_JAL: begin
                    o_res.imm = sext32(w_imm_j);
                    o_res.fmt = FMT_J;
                end
                default: begin
                    o_res.imm = 64'd0;
                    o_res.fmt = FMT_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready on both sides.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_instr is the raw instruction
//   out_valid/out_ready   output handshake
//   out_imm [XLEN-1:0]    extended immediate
//   out_fmt [2:0]         format code (imm_fmt_t)
//   out_illegal           instr[1:0] != 2'b11
// One output register plus an optional one-entry skid holding decoded
// results, so in_ready depends only on registered state when SKID=1.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam bit SKID_EN = (SKID != 0);

    imm_res_t w_dec;
    imm_res_t r_out;
    imm_res_t r_skid;
    logic     r_out_valid;
    logic     r_skid_valid;
    logic     w_out_load_en;
    logic     w_in_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr (in_instr),
        .o_res   (w_dec)
    );

    // Output register may take a new word when empty or being consumed.
    assign w_out_load_en = !r_out_valid || out_ready;
    assign in_ready      = SKID_EN ? !r_skid_valid : w_out_load_en;
    assign w_in_fire     = in_valid && in_ready;

    // Output stage and skid: skid drains first so ordering is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_out_load_en) begin
                if (r_skid_valid) begin
                    // in_ready was low, so no input can arrive this edge.
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire && SKID_EN) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out.imm[XLEN-1:0];
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;

    // Upper immediate bits are only meaningful for XLEN=64.
    generate
        if (XLEN < IMM_MAX_W) begin : g_trim
            logic w_unused_imm_hi;
            assign w_unused_imm_hi = ^r_out.imm[IMM_MAX_W-1:XLEN];
        end
    endgenerate

endmodule
